// File: rtl/sc_config_commit.sv
// Staged sc_config write commit: entries queue in IDLE, arm on commit, drain as Avalon-MM writes on a frame pulse.
// Latency: first write in the cycle after frame_start_i; one write per cycle, done_o one cycle after the last write.
// Backpressure: m_waitrequest_n_i=0 holds the current write; stg_full_o rejects pushes. Watchdog: SC_CONFIG_COMMIT_WATCHDOG_EN.

module sc_config_commit_fifo #(
    parameter int WIDTH = 46,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clr) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign level    = wr_ptr - rd_ptr;
endmodule

module sc_config_commit #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [9:0]               stg_addr_i,
    input  logic [31:0]              stg_data_i,
    input  logic [3:0]               stg_be_i,
    input  logic                     stg_push_i,
    output logic                     stg_full_o,
    output logic [$clog2(DEPTH):0]   stg_level_o,
    input  logic                     commit_req_i,
    input  logic                     flush_i,
    input  logic                     frame_start_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overflow_o,
    output logic                     timeout_o,
    output logic [9:0]               m_address_o,
    output logic [31:0]              m_writedata_o,
    output logic [3:0]               m_byteenable_o,
    output logic                     m_write_o,
    output logic                     m_chipselect_o,
    input  logic                     m_waitrequest_n_i
);
    localparam int LW = $clog2(DEPTH) + 1;

    if (DEPTH < 4 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("sc_config_commit: illegal DEPTH or TIMEOUT_CYCLES");
    end

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
    } stg_entry_t;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DRAIN, S_DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    stg_entry_t push_ent;
    stg_entry_t head_ent;
    logic       push_acc;
    logic       pop;
    logic       flush_eff;
    logic       wd_hit;
    logic       ovf_q;

    assign push_ent  = '{addr: stg_addr_i, data: stg_data_i, be: stg_be_i};
    assign flush_eff = flush_i && (state == S_IDLE || state == S_ARMED);
    assign stg_full_o = (stg_level_o == LW'(DEPTH)) || (state != S_IDLE);
    assign push_acc  = stg_push_i && !stg_full_o && !flush_eff;
    assign pop       = (state == S_DRAIN) && m_waitrequest_n_i;

    sc_config_commit_fifo #(
        .WIDTH ($bits(stg_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr      (flush_eff),
        .push     (push_acc),
        .push_dat (push_ent),
        .pop      (pop),
        .head_dat (head_ent),
        .level    (stg_level_o)
    );

`ifdef SC_CONFIG_COMMIT_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_ONE  = 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    logic [WDW-1:0] wd_cnt;
    logic           tmo_q;

    // Counter sits at zero outside ARMED, so it restarts on every ARMED entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_cnt <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wd_cnt <= (state == S_ARMED && state_nxt == S_ARMED) ? wd_cnt + WD_ONE : '0;
            if (flush_eff)
                tmo_q <= 1'b0;
            else if (wd_hit && !frame_start_i)
                tmo_q <= 1'b1;
        end
    end

    assign wd_hit    = (state == S_ARMED) && (wd_cnt == WD_LAST);
    assign timeout_o = tmo_q;
`else
    assign wd_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_IDLE;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush_eff)
                ovf_q <= 1'b0;
            else if (stg_push_i && stg_full_o)
                ovf_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (flush_i)
                    state_nxt = S_IDLE;
                else if (commit_req_i)
                    state_nxt = (stg_level_o != '0 || push_acc) ? S_ARMED : S_DONE;
            end
            S_ARMED: begin
                if (flush_i)
                    state_nxt = S_IDLE;
                else if (frame_start_i || wd_hit)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && stg_level_o == LW'(1))
                    state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Master fields are masked to zero outside DRAIN so stale FIFO contents never leak.
    assign m_write_o      = (state == S_DRAIN);
    assign m_chipselect_o = m_write_o;
    assign m_address_o    = m_write_o ? head_ent.addr : '0;
    assign m_writedata_o  = m_write_o ? head_ent.data : '0;
    assign m_byteenable_o = m_write_o ? head_ent.be   : '0;

    assign busy_o     = (state == S_ARMED) || (state == S_DRAIN);
    assign done_o     = (state == S_DONE);
    assign overflow_o = ovf_q;
endmodule
